i2s_tx_serializer: RTL and testbench

- Downstream audio stage of the codec_I2C_I2S AXI4-Lite peripheral.
- Takes left/right PCM sample pairs from the register/sample path over a valid/ready handshake.
- Serializes them onto a Philips-I2S bus (BCLK, LRCLK, SDATA) toward the external codec.
- Generates BCLK from ACLK, holds one frame of buffering, and reports underruns.

---
 rtl/i2s_pkg.sv | 17 +
 rtl/i2s_bclk_gen.sv | 44 ++++
 rtl/i2s_tx_serializer.sv | 164 ++++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and default widths for the I2S transmit path.
package i2s_pkg;

  localparam int unsigned DEF_DATA_W = 24;
  localparam int unsigned DEF_SLOT_W = 32;

  typedef enum logic {
    StIdle,
    StRun
  } i2s_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] left;
    logic [DEF_DATA_W-1:0] right;
  } sample_pair_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: BCLK toggles every BCLK_DIV ACLK cycles while run is high.
module i2s_bclk_gen #(
  parameter int unsigned BCLK_DIV = 2
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic run,
  output logic bclk,
  output logic fall_tick
);

  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             term;

  // Divider next-state; held at zero whenever the serializer is idle.
  always_comb begin
    term      = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    div_cnt_d = term ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = term ? ~bclk_q : bclk_q;
    if (!run) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk      = bclk_q;
  // Asserted in the cycle whose closing edge drives BCLK from 1 to 0.
  assign fall_tick = run && term && bclk_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips-I2S transmitter: one-pair input buffer, frame FSM, serial data select, underrun count.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned SLOT_W   = DEF_SLOT_W,
  parameter int unsigned BCLK_DIV = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_sdata,
  output logic              frame_start,
  output logic              underrun,
  output logic [CNT_W-1:0]  underrun_cnt
);

  localparam int unsigned IDX_W = $clog2(2 * SLOT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * SLOT_W - 1);
  localparam logic [IDX_W-1:0] SLOT_IDX = IDX_W'(SLOT_W);

  // Data bit for a given frame position; the MSB sits one BCLK after the slot start.
  function automatic logic ser_bit(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] l,
                                   input logic [DATA_W-1:0] r);
    int               p;
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] sh;
    if (idx >= SLOT_IDX) begin
      p = int'(idx - SLOT_IDX);
      w = r;
    end else begin
      p = int'(idx);
      w = l;
    end
    if (p >= 1 && p <= int'(DATA_W)) begin
      sh = w >> (int'(DATA_W) - p);
      return sh[0];
    end
    return 1'b0;
  endfunction

  i2s_state_t        state_q, state_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic              buf_full_q, buf_full_d;
  logic              lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic              frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run, fall_tick, accept, frame_end, load;

  assign run     = (state_q == StRun);
  assign s_ready = !buf_full_q && !ARESET;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .run       (run),
    .bclk      (i2s_bclk),
    .fall_tick (fall_tick)
  );

  // FSM, buffer and serial output next-state.
  always_comb begin
    accept    = s_valid && s_ready;
    frame_end = run && fall_tick && (bit_idx_q == LAST_IDX);
    load      = enable && ((state_q == StIdle) || frame_end);

    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    act_l_d       = act_l_q;
    act_r_d       = act_r_q;
    buf_l_d       = buf_l_q;
    buf_r_d       = buf_r_q;
    buf_full_d    = buf_full_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    cnt_d         = cnt_q;

    if (run && fall_tick) begin
      bit_idx_d = bit_idx_q + IDX_W'(1);
      lrclk_d   = (bit_idx_d >= SLOT_IDX);
      sdata_d   = ser_bit(bit_idx_d, act_l_q, act_r_q);
    end

    if (frame_end && !enable) begin
      state_d   = StIdle;
      bit_idx_d = '0;
      lrclk_d   = 1'b0;
      sdata_d   = 1'b0;
    end

    // The load sees the buffer as it was before any same-cycle accept.
    if (load) begin
      state_d       = StRun;
      bit_idx_d     = '0;
      lrclk_d       = 1'b0;
      sdata_d       = 1'b0;
      frame_start_d = 1'b1;
      underrun_d    = !buf_full_q;
      act_l_d       = buf_full_q ? buf_l_q : '0;
      act_r_d       = buf_full_q ? buf_r_q : '0;
      buf_full_d    = 1'b0;
      if (!buf_full_q && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (accept) begin
      buf_l_d    = s_left;
      buf_r_d    = s_right;
      buf_full_d = 1'b1;
    end
  end

  // State registers; reset aborts any frame and drops the buffered pair.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= StIdle;
      bit_idx_q     <= '0;
      act_l_q       <= '0;
      act_r_q       <= '0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
      buf_full_q    <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      act_l_q       <= act_l_d;
      act_r_q       <= act_r_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      buf_full_q    <= buf_full_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      cnt_q         <= cnt_d;
    end
  end

  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = sdata_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer with a bus monitor that decodes each I2S frame.
module tb_i2s_tx_serializer;
  import i2s_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_left = '0;
  logic [23:0] s_right = '0;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun;
  logic [15:0] underrun_cnt;

  i2s_tx_serializer #(
    .DATA_W   (24),
    .SLOT_W   (32),
    .BCLK_DIV (2),
    .CNT_W    (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_left       (s_left),
    .s_right      (s_right),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          fmt_bad;
    logic        ur;
  } frame_t;

  frame_t frames[$];
  frame_t cur;
  int     n_checks = 0;
  int     n_errors = 0;
  int     fs_cnt = 0;
  int     per_bad = 0;
  int     since_rise = 100;
  int     nbit = 0;
  bit     in_frame = 1'b0;
  logic   bclk_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decode the bus at every BCLK rise, sampled on the ACLK falling edge.
  initial begin
    int p;
    forever begin
      @(negedge ACLK);
      since_rise++;
      if (ARESET) begin
        in_frame = 1'b0;
      end else begin
        if (frame_start) begin
          fs_cnt++;
          in_frame = 1'b1;
          nbit = 0;
          cur = '{l: '0, r: '0, fmt_bad: 0, ur: underrun};
        end
        if (i2s_bclk && !bclk_prev) begin
          if (since_rise >= 1 && since_rise <= 12 && since_rise != 4) per_bad++;
          since_rise = 0;
          if (in_frame) begin
            if (i2s_lrclk !== (nbit >= 32)) cur.fmt_bad++;
            p = nbit % 32;
            if (p >= 1 && p <= 24) begin
              if (nbit < 32) cur.l[24-p] = i2s_sdata;
              else cur.r[24-p] = i2s_sdata;
            end else if (i2s_sdata !== 1'b0) begin
              cur.fmt_bad++;
            end
            nbit++;
            if (nbit == 64) begin
              frames.push_back(cur);
              in_frame = 1'b0;
            end
          end
        end
      end
      bclk_prev = i2s_bclk;
    end
  end

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    bit ok = 1'b0;
    int k = 0;
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    while (!ok && k < 600) begin
      ok = s_ready;
      @(negedge ACLK);
      k++;
    end
    s_valid = 1'b0;
    check_eq("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_frames(input int n, input string tag);
    int k = 0;
    while (frames.size() < n && k < 1500) begin
      @(negedge ACLK);
      k++;
    end
    check_eq(tag, 32'(frames.size() >= n), 32'd1);
  endtask

  task automatic wait_fs(input int target, input string tag);
    int k = 0;
    while (fs_cnt < target && k < 1500) begin
      @(negedge ACLK);
      k++;
    end
    check_eq(tag, 32'(fs_cnt >= target), 32'd1);
  endtask

  task automatic check_frame(input int i, input string tag, input logic [23:0] l,
                             input logic [23:0] r, input logic ur);
    frame_t f;
    f = (frames.size() > i) ? frames[i] : '{l: '0, r: '0, fmt_bad: 99, ur: 1'b0};
    check_eq({tag, "_left"}, 32'(f.l), 32'(l));
    check_eq({tag, "_right"}, 32'(f.r), 32'(r));
    check_eq({tag, "_format"}, 32'(f.fmt_bad), 32'd0);
    check_eq({tag, "_underrun"}, 32'(f.ur), 32'(ur));
  endtask

  sample_pair_t vec[3];
  int           fs_base;

  initial begin
    vec[0] = '{left: 24'h123456, right: 24'hFEDCBA};
    vec[1] = '{left: 24'h800001, right: 24'h7FFFFE};
    vec[2] = '{left: 24'h0F0F0F, right: 24'hC3C3C3};

    // Reset with s_valid high: nothing accepted, all outputs low.
    s_valid = 1'b1;
    s_left  = 24'h111111;
    s_right = 24'h222222;
    repeat (3) begin
      @(negedge ACLK);
      check_eq("reset_outs", 32'({s_ready, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun}),
               32'd0);
      check_eq("reset_cnt", 32'(underrun_cnt), 32'd0);
    end
    ARESET  = 1'b0;
    s_valid = 1'b0;
    @(negedge ACLK);
    check_eq("release_ready", 32'(s_ready), 32'd1);
    check_eq("release_cnt", 32'(underrun_cnt), 32'd0);

    // Single frame.
    push(24'hA5A5A5, 24'h5A5A5A);
    check_eq("single_full", 32'(s_ready), 32'd0);
    enable = 1'b1;
    @(negedge ACLK);
    enable = 1'b0;
    check_eq("single_fs", 32'(frame_start), 32'd1);
    check_eq("single_ur", 32'(underrun), 32'd0);
    wait_frames(1, "single_wait");
    repeat (20) @(negedge ACLK);
    check_frame(0, "single", 24'hA5A5A5, 24'h5A5A5A, 1'b0);
    check_eq("single_fs_once", 32'(fs_cnt), 32'd1);
    check_eq("single_idle_bus", 32'({i2s_bclk, i2s_lrclk, i2s_sdata}), 32'd0);
    check_eq("single_ready", 32'(s_ready), 32'd1);

    // Underrun, then a pair pushed mid-frame.
    frames.delete();
    fs_base = fs_cnt;
    enable = 1'b1;
    @(negedge ACLK);
    check_eq("ur_fs", 32'(frame_start), 32'd1);
    check_eq("ur_pulse", 32'(underrun), 32'd1);
    check_eq("ur_cnt", 32'(underrun_cnt), 32'd1);
    repeat (100) @(negedge ACLK);
    push(24'h000001, 24'h800000);
    wait_fs(fs_base + 2, "ur_second_start");
    enable = 1'b0;
    wait_frames(2, "ur_wait");
    check_frame(0, "ur_f0", 24'h0, 24'h0, 1'b1);
    check_frame(1, "ur_f1", 24'h000001, 24'h800000, 1'b0);
    check_eq("ur_cnt_after", 32'(underrun_cnt), 32'd1);

    // Back-to-back frames from a fresh reset.
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    repeat (20) @(negedge ACLK);
    frames.delete();
    fs_base = fs_cnt;
    per_bad = 0;
    push(vec[0].left, vec[0].right);
    check_eq("b2b_full0", 32'(s_ready), 32'd0);
    enable = 1'b1;
    push(vec[1].left, vec[1].right);
    check_eq("b2b_full1", 32'(s_ready), 32'd0);
    push(vec[2].left, vec[2].right);
    wait_fs(fs_base + 4, "b2b_fourth_start");
    enable = 1'b0;
    wait_frames(4, "b2b_wait");
    for (int i = 0; i < 3; i++) check_frame(i, "b2b", vec[i].left, vec[i].right, 1'b0);
    check_frame(3, "b2b_f3", 24'h0, 24'h0, 1'b1);
    check_eq("b2b_cnt", 32'(underrun_cnt), 32'd1);
    check_eq("b2b_bclk_period", 32'(per_bad), 32'd0);

    // Enable dropped at bit 10: frame completes, buffered pair is kept.
    repeat (20) @(negedge ACLK);
    frames.delete();
    fs_base = fs_cnt;
    push(24'h13579B, 24'h2468AC);
    enable = 1'b1;
    @(negedge ACLK);
    check_eq("drop_fs", 32'(frame_start), 32'd1);
    repeat (41) @(negedge ACLK);
    enable = 1'b0;
    push(24'hDEAD01, 24'hBEEF02);
    wait_frames(1, "drop_wait");
    repeat (20) @(negedge ACLK);
    check_frame(0, "drop", 24'h13579B, 24'h2468AC, 1'b0);
    check_eq("drop_idle_bus", 32'({i2s_bclk, i2s_lrclk, i2s_sdata}), 32'd0);
    check_eq("drop_kept", 32'(s_ready), 32'd0);
    check_eq("drop_fs_count", 32'(fs_cnt - fs_base), 32'd1);
    enable = 1'b1;
    @(negedge ACLK);
    enable = 1'b0;
    check_eq("reen_fs", 32'(frame_start), 32'd1);
    check_eq("reen_ur", 32'(underrun), 32'd0);
    wait_frames(2, "reen_wait");
    check_frame(1, "reen", 24'hDEAD01, 24'hBEEF02, 1'b0);
    check_eq("reen_cnt", 32'(underrun_cnt), 32'd1);

    // Reset at bit 40 with the buffer full.
    repeat (20) @(negedge ACLK);
    frames.delete();
    push(24'h111111, 24'h222222);
    enable = 1'b1;
    @(negedge ACLK);
    enable = 1'b0;
    push(24'h333333, 24'h444444);
    repeat (158) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    check_eq("midrst_outs", 32'({s_ready, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun}),
             32'd0);
    check_eq("midrst_cnt", 32'(underrun_cnt), 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check_eq("midrst_ready", 32'(s_ready), 32'd1);
    repeat (20) @(negedge ACLK);
    check_eq("midrst_no_frame", 32'(frames.size()), 32'd0);
    enable = 1'b1;
    @(negedge ACLK);
    enable = 1'b0;
    check_eq("midrst_discard_ur", 32'(underrun), 32'd1);
    wait_frames(1, "midrst_wait");
    check_frame(0, "midrst", 24'h0, 24'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
